riscv_fetch: RTL
================

Name: riscv_fetch

Overview:
Instruction fetch stage that sits between riscv_memory (instruction port) and riscv_decoder. It owns the PC and issues word reads on iaddr/ird. It captures irdata into a small FIFO of {pc, opcode} pairs and presents them to decode through a valid/accept handshake. Branch/jump redirects from the execute stage flush the FIFO and any in-flight read.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
FIFO_DEPTH, 2, number of {pc, opcode} entries buffered; power of 2, minimum 2.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
reset_i  input  1  asynchronous, active-high reset.
fetch_enable_i  input  1  level; 1 = fetching permitted.
iaddr_o  output  32  instruction read address to riscv_memory.
ird_o  output  1  instruction read strobe; one-cycle pulse per request.
irdata_i  input  32  instruction data from riscv_memory; valid exactly 1 cycle after ird_o.
branch_request_i  input  1  redirect pulse from execute.
branch_pc_i  input  32  redirect target; sampled when branch_request_i=1.
if_valid_o  output  1  FIFO head holds a valid instruction.
if_opcode_o  output  32  head opcode; drives the decoder's if_opcode_w.
if_pc_o  output  32  PC of the head opcode.
id_accept_i  input  1  decode consumes the head when if_valid_o && id_accept_i.
fetch_misaligned_o  output  1  sticky flag: branch target had [1:0]!=0.

Behaviour:
- Reset (async assert, sync release): state IDLE, pc=RESET_PC, iaddr_o=RESET_PC, ird_o=0, FIFO empty, if_valid_o=0, if_opcode_o=0, if_pc_o=0, fetch_misaligned_o=0, inflight=0, drop=0. Reset mid-operation discards everything; the in-flight response is ignored.
- FSM states:
  - IDLE: no requests. Goes to RUN when fetch_enable_i=1.
  - RUN: issues requests. Goes to IDLE when fetch_enable_i=0; already-buffered entries remain visible and an in-flight read still completes.
  - HALT: entered on a misaligned redirect. No requests. Leaves only on an aligned branch_request_i, to RUN (or IDLE if fetch_enable_i=0).
- Issue rule (RUN, no branch this cycle): ird_o=1 and iaddr_o=pc when occupancy + inflight < FIFO_DEPTH, where occupancy is counted after this cycle's pop. On issue: pc <= pc+4 (wraps at 2^32 to 0); inflight <= 1.
- Response: in the cycle after ird_o, irdata_i is written to the FIFO tail with its request PC, unless drop=1. Either way, inflight clears.
- Throughput: one instruction per cycle sustained when decode accepts every cycle.
- Push and pop in the same cycle is legal when full. Occupancy is unchanged.
- Latency: if_valid_o rises 2 cycles after the first ird_o (request cycle, then capture edge). Head outputs are registered from the FIFO.
- Redirect (branch_request_i=1) has priority over issue, pop and push in that cycle:
  - FIFO is flushed and if_valid_o=0 next cycle.
  - If inflight=1 or ird_o is high in the same cycle, drop <= 1 to discard the following response.
  - Aligned target: pc <= branch_pc_i, and the next request goes out the following cycle.
  - Misaligned target: fetch_misaligned_o <= 1, state <= HALT, pc unchanged.
- Branch and accept in the same cycle: branch wins and the accepted entry is flushed with the rest.
- A branch in HALT with an aligned target clears fetch_misaligned_o.
- Empty FIFO: if_valid_o=0 and if_opcode_o/if_pc_o hold their last values. id_accept_i is ignored.
- Full FIFO: no issue; pc holds.

Decomposition:
- Shared package riscv_pkg holds:
  - RESET_PC default and the NOP opcode 32'h0000_0013;
  - fetch FSM state encodings: IDLE=2'd0, RUN=2'd1, HALT=2'd2;
  - the SIZE_* constants already used by the memory.
- One sub-module: riscv_fetch_fifo.
  - Synchronous FIFO, width 64 ({pc, opcode}), depth FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Same async active-high reset.

Test Plan:
1. Reset, fetch_enable_i=1, memory preloaded at 0x0..0x1c, id_accept_i=1 -> ird_o pulses with iaddr_o 0x0, 0x4, 0x8 on consecutive cycles; if_pc_o 0x0, 0x4, … with the matching opcodes, one per cycle, first valid 2 cycles after the first ird_o.
2. id_accept_i=0 for 6 cycles -> exactly FIFO_DEPTH (2) entries captured (pc 0x0, 0x4), ird_o low, iaddr_o holds; accept re-asserted -> 0x8 fetched with no entry lost or duplicated.
3. branch_request_i with branch_pc_i=0x40 while a read of 0x8 is in flight and the FIFO holds 0x4 -> the 0x8 data is dropped, if_valid_o=0 for 2 cycles, then if_pc_o=0x40 followed by 0x44.
4. branch_pc_i=0x42 -> fetch_misaligned_o=1, no ird_o; then branch_pc_i=0x80 -> flag clears and fetching resumes at 0x80.
5. branch_pc_i=32'hFFFF_FFFC, accept=1 -> pc sequence 0xFFFFFFFC then 0x00000000.
6. reset_i asserted mid-fetch (FIFO full, read in flight) -> all outputs at reset values immediately; after release, the first request is at RESET_PC and the stale response is not captured.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and fetch FSM encodings for the riscv core slice
package riscv_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: synchronous FIFO of {pc, opcode} entries with flush
// Ports: i_push/i_data write the tail, i_pop advances the head (o_data),
//        i_flush empties it; o_full/o_empty/o_count report occupancy.
module riscv_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge i_clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  assign o_data = r_mem[r_rd];
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch stage owning the PC, buffering {pc, opcode} for decode
// Ports: iaddr_o/ird_o/irdata_i talk to instruction memory (data one cycle after ird_o);
//        if_valid_o/if_pc_o/if_opcode_o/id_accept_i hand instructions to decode;
//        branch_request_i/branch_pc_i redirect; fetch_misaligned_o flags a bad target.
module riscv_fetch import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_enable_i,
  output logic [31:0] iaddr_o,
  output logic        ird_o,
  input  logic [31:0] irdata_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_opcode_o,
  output logic [31:0] if_pc_o,
  input  logic        id_accept_i,
  output logic        fetch_misaligned_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e r_state;
  logic [31:0] r_pc, r_rsp_pc, r_hold_pc, r_hold_op;
  logic r_inflight, r_drop, r_misaligned;
  logic [63:0] w_head;
  logic [CW-1:0] w_count;
  logic w_empty, w_full, w_pop, w_push, w_aligned;
  assign w_aligned = branch_pc_i[1:0] == 2'b00;
  assign w_pop = !w_empty && id_accept_i && !branch_request_i;
  assign w_push = r_inflight && !r_drop && !branch_request_i;
  // The response landing this cycle (r_inflight) already owns a slot, so it is
  // counted against the post-pop occupancy before a new request is allowed out.
  assign ird_o = r_state == ST_RUN && !(w_full && !w_pop) &&
                 (int'(w_count) - int'(w_pop) + int'(r_inflight) < FIFO_DEPTH);
  assign iaddr_o = r_pc;
  riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (reset_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_request_i),
    .i_data  ({r_rsp_pc, irdata_i}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_pc <= RESET_PC;
      r_rsp_pc <= '0;
      r_inflight <= 1'b0;
      r_drop <= 1'b0;
      r_misaligned <= 1'b0;
      r_hold_pc <= '0;
      r_hold_op <= '0;
    end else begin
      r_state <= (branch_request_i && !w_aligned) ? ST_HALT :
                 (r_state == ST_HALT && !branch_request_i) ? ST_HALT :
                 fetch_enable_i ? ST_RUN : ST_IDLE;
      r_pc <= branch_request_i ? (w_aligned ? branch_pc_i : r_pc) :
              ird_o ? r_pc + 32'd4 : r_pc;
      r_inflight <= ird_o;
      if (ird_o) r_rsp_pc <= r_pc;
      // A response in the redirect cycle is blocked directly; only a request
      // issued alongside the redirect needs its later response discarded.
      r_drop <= branch_request_i && ird_o;
      if (branch_request_i) r_misaligned <= !w_aligned;
      if (!w_empty) {r_hold_pc, r_hold_op} <= w_head;
    end
  assign if_valid_o = !w_empty;
  assign if_pc_o = w_empty ? r_hold_pc : w_head[63:32];
  assign if_opcode_o = w_empty ? r_hold_op : w_head[31:0];
  assign fetch_misaligned_o = r_misaligned;
endmodule
